// File: rtl/calculadora_pkg.sv
// Shared definitions for the calculator keypad: FSM states, key codes,
// operator codes and key decoding helpers.
package calculadora_pkg;

    localparam int SCAN_CICLOS_DEF       = 1000;
    localparam int ANTIREBOTE_CICLOS_DEF = 50000;

    typedef enum logic [2:0] {
        ESCANEAR,
        ANTIREBOTE_PRESION,
        VALIDA,
        ESPERAR_SOLTAR,
        ANTIREBOTE_SOLTAR
    } estado_t;

    typedef enum logic [1:0] {
        CLASE_DIGITO,
        CLASE_OPERADOR,
        CLASE_IGUAL,
        CLASE_BORRAR
    } clase_t;

    localparam logic [3:0] TECLA_0   = 4'h0;
    localparam logic [3:0] TECLA_1   = 4'h1;
    localparam logic [3:0] TECLA_2   = 4'h2;
    localparam logic [3:0] TECLA_3   = 4'h3;
    localparam logic [3:0] TECLA_4   = 4'h4;
    localparam logic [3:0] TECLA_5   = 4'h5;
    localparam logic [3:0] TECLA_6   = 4'h6;
    localparam logic [3:0] TECLA_7   = 4'h7;
    localparam logic [3:0] TECLA_8   = 4'h8;
    localparam logic [3:0] TECLA_9   = 4'h9;
    localparam logic [3:0] TECLA_A   = 4'hA;
    localparam logic [3:0] TECLA_B   = 4'hB;
    localparam logic [3:0] TECLA_C   = 4'hC;
    localparam logic [3:0] TECLA_D   = 4'hD;
    localparam logic [3:0] TECLA_AST = 4'hE;
    localparam logic [3:0] TECLA_NUM = 4'hF;

    localparam logic [1:0] OP_SUMA  = 2'b00;
    localparam logic [1:0] OP_RESTA = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    // Physical layout: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D
    function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
        logic [3:0] c;
        case ({fila, col})
            4'b00_00: c = TECLA_1;
            4'b00_01: c = TECLA_2;
            4'b00_10: c = TECLA_3;
            4'b00_11: c = TECLA_A;
            4'b01_00: c = TECLA_4;
            4'b01_01: c = TECLA_5;
            4'b01_10: c = TECLA_6;
            4'b01_11: c = TECLA_B;
            4'b10_00: c = TECLA_7;
            4'b10_01: c = TECLA_8;
            4'b10_10: c = TECLA_9;
            4'b10_11: c = TECLA_C;
            4'b11_00: c = TECLA_AST;
            4'b11_01: c = TECLA_0;
            4'b11_10: c = TECLA_NUM;
            default:  c = TECLA_D;
        endcase
        return c;
    endfunction

    function automatic clase_t clase_tecla(input logic [3:0] c);
        clase_t k;
        if (c <= TECLA_9)        k = CLASE_DIGITO;
        else if (c == TECLA_AST) k = CLASE_BORRAR;
        else if (c == TECLA_NUM) k = CLASE_IGUAL;
        else                     k = CLASE_OPERADOR;
        return k;
    endfunction

    function automatic logic [1:0] op_de_tecla(input logic [3:0] c);
        logic [1:0] op;
        case (c)
            TECLA_A: op = OP_SUMA;
            TECLA_B: op = OP_RESTA;
            TECLA_C: op = OP_MULT;
            default: op = OP_DIV;
        endcase
        return op;
    endfunction

    // True when exactly one active-low column is asserted
    function automatic logic una_columna(input logic [3:0] col);
        return (col == 4'b1110) || (col == 4'b1101) || (col == 4'b1011) || (col == 4'b0111);
    endfunction

    function automatic logic [1:0] indice_columna(input logic [3:0] col);
        logic [1:0] idx;
        case (col)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/modulo_teclado_if.sv
// Keypad pins plus the decoded key/strobe bus towards the calculator core.
interface modulo_teclado_if;
    logic [3:0] columnas;
    logic [3:0] filas;
    logic [3:0] tecla;
    logic       numero_en;
    logic       operando_en;
    logic [1:0] operacion;
    logic       igual_en;
    logic       borrar_en;

    modport master (
        input  columnas,
        output filas, tecla, numero_en, operando_en, operacion, igual_en, borrar_en
    );

    modport slave (
        output columnas,
        input  filas, tecla, numero_en, operando_en, operacion, igual_en, borrar_en
    );
endinterface

// File: rtl/modulo_teclado_sincronizador.sv
// Two-flop synchronizer; resets to all-ones (idle level of the columns).
module sincronizador #(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ANCHO-1:0] d,
    output logic [ANCHO-1:0] q
);
    logic [ANCHO-1:0] meta;

    // Two register stages to settle metastability of the asynchronous input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/modulo_teclado.sv
// Matrix keypad scanner with press/release debounce and key-class strobes.
module modulo_teclado
    import calculadora_pkg::*;
#(
    parameter int SCAN_CICLOS       = SCAN_CICLOS_DEF,
    parameter int ANTIREBOTE_CICLOS = ANTIREBOTE_CICLOS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    modulo_teclado_if.master  bus
);
    localparam int SCAN_W = $clog2(SCAN_CICLOS);
    localparam int DEB_W  = $clog2(ANTIREBOTE_CICLOS + 1);

    estado_t             estado;
    logic [3:0]          col_s;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [DEB_W-1:0]    deb_cnt;
    logic [1:0]          fila_idx;
    logic [1:0]          col_idx;
    logic [1:0]          fila_sig;
    logic [3:0]          col_esperada;
    logic [3:0]          codigo;

    sincronizador #(.ANCHO(4)) u_sinc (
        .clk   (clk),
        .reset (reset),
        .d     (bus.columnas),
        .q     (col_s)
    );

    // Derived values for the latched key and the next row in the scan
    always_comb begin
        fila_sig     = fila_idx + 2'd1;
        col_esperada = ~(4'b0001 << col_idx);
        codigo       = codigo_tecla(fila_idx, col_idx);
    end

    // Scan/debounce FSM with registered row drive, key code and strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado          <= ESCANEAR;
            bus.filas       <= 4'b1110;
            fila_idx        <= 2'd0;
            col_idx         <= 2'd0;
            scan_cnt        <= '0;
            deb_cnt         <= '0;
            bus.tecla       <= TECLA_0;
            bus.operacion   <= OP_SUMA;
            bus.numero_en   <= 1'b0;
            bus.operando_en <= 1'b0;
            bus.igual_en    <= 1'b0;
            bus.borrar_en   <= 1'b0;
        end else begin
            bus.numero_en   <= 1'b0;
            bus.operando_en <= 1'b0;
            bus.igual_en    <= 1'b0;
            bus.borrar_en   <= 1'b0;
            case (estado)
                ESCANEAR: begin
                    if (scan_cnt == SCAN_W'(SCAN_CICLOS - 1)) begin
                        scan_cnt <= '0;
                        if (una_columna(col_s)) begin
                            col_idx <= indice_columna(col_s);
                            deb_cnt <= '0;
                            estado  <= ANTIREBOTE_PRESION;
                        end else begin
                            fila_idx  <= fila_sig;
                            bus.filas <= ~(4'b0001 << fila_sig);
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                ANTIREBOTE_PRESION: begin
                    if (col_s == col_esperada) begin
                        if (deb_cnt == DEB_W'(ANTIREBOTE_CICLOS - 1)) begin
                            deb_cnt <= '0;
                            estado  <= VALIDA;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_cnt   <= '0;
                        fila_idx  <= fila_sig;
                        bus.filas <= ~(4'b0001 << fila_sig);
                        estado    <= ESCANEAR;
                    end
                end
                VALIDA: begin
                    bus.tecla <= codigo;
                    case (clase_tecla(codigo))
                        CLASE_DIGITO:   bus.numero_en <= 1'b1;
                        CLASE_OPERADOR: begin
                            bus.operando_en <= 1'b1;
                            bus.operacion   <= op_de_tecla(codigo);
                        end
                        CLASE_IGUAL:    bus.igual_en  <= 1'b1;
                        default:        bus.borrar_en <= 1'b1;
                    endcase
                    estado <= ESPERAR_SOLTAR;
                end
                ESPERAR_SOLTAR: begin
                    if (col_s[col_idx]) begin
                        deb_cnt <= '0;
                        estado  <= ANTIREBOTE_SOLTAR;
                    end
                end
                ANTIREBOTE_SOLTAR: begin
                    if (col_s[col_idx]) begin
                        if (deb_cnt == DEB_W'(ANTIREBOTE_CICLOS - 1)) begin
                            deb_cnt   <= '0;
                            fila_idx  <= fila_sig;
                            bus.filas <= ~(4'b0001 << fila_sig);
                            estado    <= ESCANEAR;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_cnt <= '0;
                        estado  <= ESPERAR_SOLTAR;
                    end
                end
                default: estado <= ESCANEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_modulo_teclado.sv
// Directed bench for modulo_teclado with a behavioural keypad matrix.
module tb_modulo_teclado;
    localparam int DIG = 0;
    localparam int OPR = 1;
    localparam int IGU = 2;
    localparam int BOR = 3;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] t;
        int         clase;
        logic [1:0] op;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    modulo_teclado_if tif();

    modulo_teclado #(.SCAN_CICLOS(4), .ANTIREBOTE_CICLOS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    // Pressed keys per row (1 = pressed); a pressed key pulls its column low
    // only while its row is driven low
    logic [3:0] mapa [4];
    always_comb begin
        tif.columnas = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!tif.filas[r]) tif.columnas = tif.columnas & ~mapa[r];
    end

    int n_num = 0, n_op = 0, n_ig = 0, n_bo = 0, n_multi = 0;
    int checks = 0, errors = 0;

    // Strobe counter; also flags any cycle with more than one strobe
    always @(posedge clk) begin
        n_num <= n_num + int'(tif.numero_en);
        n_op  <= n_op  + int'(tif.operando_en);
        n_ig  <= n_ig  + int'(tif.igual_en);
        n_bo  <= n_bo  + int'(tif.borrar_en);
        if ((int'(tif.numero_en) + int'(tif.operando_en) + int'(tif.igual_en) + int'(tif.borrar_en)) > 1)
            n_multi <= n_multi + 1;
    end

    function automatic int total();
        return n_num + n_op + n_ig + n_bo;
    endfunction

    function automatic int cuenta(int clase);
        case (clase)
            DIG:     return n_num;
            OPR:     return n_op;
            IGU:     return n_ig;
            default: return n_bo;
        endcase
    endfunction

    task automatic check(string nombre, int actual, int esperado);
        checks++;
        if (actual != esperado) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nombre, actual, esperado);
        end
    endtask

    task automatic esperar_strobe(int t0, int limite, output bit visto);
        visto = 1'b0;
        for (int i = 0; i < limite; i++) begin
            @(negedge clk);
            if (total() != t0) begin
                visto = 1'b1;
                break;
            end
        end
    endtask

    // Clean press: hold until a strobe appears, release, let release debounce finish
    task automatic pulsar(string nm, vec_t v);
        int  t0, k0;
        bit  visto;
        t0 = total();
        k0 = cuenta(v.clase);
        mapa[v.r][v.c] = 1'b1;
        esperar_strobe(t0, 100, visto);
        check({nm, " strobe_timeout"}, int'(visto), 1);
        repeat (10) @(negedge clk);
        mapa[v.r][v.c] = 1'b0;
        repeat (40) @(negedge clk);
        check({nm, " tecla"}, int'(tif.tecla), int'(v.t));
        check({nm, " total_strobes"}, total() - t0, 1);
        check({nm, " class_strobe"}, cuenta(v.clase) - k0, 1);
        check({nm, " operacion"}, int'(tif.operacion), int'(v.op));
    endtask

    vec_t tabla [16];

    initial begin
        int  t0, k0, malos;
        bit  visto;
        vec_t v;

        tabla[0]  = '{0, 0, 4'h1, DIG, 2'b00};
        tabla[1]  = '{0, 1, 4'h2, DIG, 2'b00};
        tabla[2]  = '{0, 2, 4'h3, DIG, 2'b00};
        tabla[3]  = '{0, 3, 4'hA, OPR, 2'b00};
        tabla[4]  = '{1, 0, 4'h4, DIG, 2'b00};
        tabla[5]  = '{1, 1, 4'h5, DIG, 2'b00};
        tabla[6]  = '{1, 2, 4'h6, DIG, 2'b00};
        tabla[7]  = '{1, 3, 4'hB, OPR, 2'b01};
        tabla[8]  = '{2, 0, 4'h7, DIG, 2'b01};
        tabla[9]  = '{2, 1, 4'h8, DIG, 2'b01};
        tabla[10] = '{2, 2, 4'h9, DIG, 2'b01};
        tabla[11] = '{2, 3, 4'hC, OPR, 2'b10};
        tabla[12] = '{3, 0, 4'hE, BOR, 2'b10};
        tabla[13] = '{3, 1, 4'h0, DIG, 2'b10};
        tabla[14] = '{3, 2, 4'hF, IGU, 2'b10};
        tabla[15] = '{3, 3, 4'hD, OPR, 2'b11};

        for (int r = 0; r < 4; r++) mapa[r] = 4'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset filas", int'(tif.filas), 4'hE);
        check("reset tecla", int'(tif.tecla), 0);
        check("reset operacion", int'(tif.operacion), 0);
        check("reset strobes", int'({tif.numero_en, tif.operando_en, tif.igual_en, tif.borrar_en}), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 16; i++) pulsar($sformatf("key%0d", i), tabla[i]);

        // '5' held 50 cycles
        t0 = total(); k0 = n_num;
        mapa[1][1] = 1'b1;
        repeat (50) @(negedge clk);
        mapa[1][1] = 1'b0;
        repeat (40) @(negedge clk);
        check("hold5 numero_en", n_num - k0, 1);
        check("hold5 other_strobes", total() - t0 - (n_num - k0), 0);
        check("hold5 tecla", int'(tif.tecla), 5);

        // '#' bouncing, then stable
        t0 = total(); k0 = n_ig;
        for (int i = 0; i < 20; i++) begin
            mapa[3][2] = ((i / 3) % 2) == 0;
            @(negedge clk);
        end
        check("bounce no_strobe", total() - t0, 0);
        mapa[3][2] = 1'b1;
        esperar_strobe(t0, 60, visto);
        check("bounce strobe_timeout", int'(visto), 1);
        repeat (10) @(negedge clk);
        mapa[3][2] = 1'b0;
        repeat (40) @(negedge clk);
        check("bounce igual_en", n_ig - k0, 1);
        check("bounce total", total() - t0, 1);
        check("bounce tecla", int'(tif.tecla), 15);

        // 'B' held 200 cycles: row stays frozen, no auto-repeat
        t0 = total(); k0 = n_op; malos = 0; visto = 1'b0;
        mapa[1][3] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (total() != t0) visto = 1'b1;
            if (visto && tif.filas != 4'b1101) malos++;
        end
        mapa[1][3] = 1'b0;
        repeat (40) @(negedge clk);
        check("holdB seen", int'(visto), 1);
        check("holdB filas_frozen_bad", malos, 0);
        check("holdB operando_en", n_op - k0, 1);
        check("holdB total", total() - t0, 1);
        check("holdB operacion", int'(tif.operacion), 1);
        check("holdB tecla", int'(tif.tecla), 11);

        // Two columns low on row2: ignored, scan proceeds to row3
        t0 = total(); visto = 1'b0;
        mapa[2] = 4'b0011;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tif.filas == 4'b0111) visto = 1'b1;
        end
        mapa[2] = 4'b0000;
        repeat (10) @(negedge clk);
        check("multi no_strobe", total() - t0, 0);
        check("multi reached_row3", int'(visto), 1);

        // Reset at debounce count 5 of '0'
        for (int i = 0; i < 40 && tif.filas == 4'b0111; i++) @(negedge clk);
        t0 = total();
        mapa[3][1] = 1'b1;
        visto = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tif.filas == 4'b0111) begin
                visto = 1'b1;
                break;
            end
        end
        check("rst0 row3_timeout", int'(visto), 1);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst0 filas", int'(tif.filas), 4'hE);
        check("rst0 tecla", int'(tif.tecla), 0);
        check("rst0 operacion", int'(tif.operacion), 0);
        check("rst0 strobes", int'({tif.numero_en, tif.operando_en, tif.igual_en, tif.borrar_en}), 0);
        repeat (3) @(negedge clk);
        mapa[3][1] = 1'b0;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rst0 no_strobe", total() - t0, 0);
        v = '{3, 1, 4'h0, DIG, 2'b00};
        pulsar("rst0 repress", v);

        // '7' accepted, glitch during release debounce, then '8'
        t0 = total(); k0 = n_num;
        mapa[2][0] = 1'b1;
        esperar_strobe(t0, 100, visto);
        check("glitch7 strobe_timeout", int'(visto), 1);
        repeat (5) @(negedge clk);
        mapa[2][0] = 1'b0;
        repeat (4) @(negedge clk);
        mapa[2][0] = 1'b1;
        repeat (3) @(negedge clk);
        mapa[2][0] = 1'b0;
        repeat (60) @(negedge clk);
        check("glitch7 numero_en", n_num - k0, 1);
        check("glitch7 total", total() - t0, 1);
        check("glitch7 tecla", int'(tif.tecla), 7);
        v = '{2, 1, 4'h8, DIG, 2'b00};
        pulsar("after_glitch 8", v);

        check("simultaneous strobes", n_multi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/modulo_teclado.md
MODULO_TECLADO -- requirements
Module: modulo_teclado

Interface
REQ-001 SHALL have parameter SCAN_CICLOS, 1000, clock cycles each keypad row is driven during scanning (minimum 3).
REQ-002 SHALL have parameter ANTIREBOTE_CICLOS, 50000, consecutive stable cycles required to accept a press or a release.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port columnas  input  4  keypad columns, active low, asynchronous to clk.
REQ-006 SHALL have port filas  output  4  row drive, one-hot active low.
REQ-007 SHALL have port tecla  output  4  code of last accepted key (digits 0-9 = 4'h0-4'h9, A-D = 4'hA-4'hD, *=4'hE, #=4'hF).
REQ-008 SHALL have port numero_en  output  1  one-cycle strobe, a digit key was accepted.
REQ-009 SHALL have port operando_en  output  1  one-cycle strobe, an operator key (A-D) was accepted.
REQ-010 SHALL have port operacion  output  2  operator code: A=00 (+), B=01 (-), C=10 (*), D=11 (/).
REQ-011 SHALL have port igual_en  output  1  one-cycle strobe, '#' accepted.
REQ-012 SHALL have port borrar_en  output  1  one-cycle strobe, '*' accepted.

Function
REQ-013 Key map SHALL be: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D (column 0 leftmost).
REQ-014 columnas SHALL pass through a two-flop synchronizer before any use; all decisions use synchronized values.
REQ-015 FSM states SHALL be ESCANEAR, ANTIREBOTE_PRESION, VALIDA, ESPERAR_SOLTAR, ANTIREBOTE_SOLTAR.
REQ-016 ESCANEAR: each row driven for SCAN_CICLOS cycles, sequence row0-row1-row2-row3-row0; columns sampled in the last cycle of the dwell.
REQ-017 ESCANEAR: exactly one low synchronized column at sample -> latch row/column, freeze filas, go ANTIREBOTE_PRESION; zero or multiple low columns -> advance to next row.
REQ-018 ANTIREBOTE_PRESION: counter increments each cycle the latched column reads low and no other column is low; any deviation -> counter clear, return to ESCANEAR at next row.
REQ-019 Counter reaching ANTIREBOTE_CICLOS SHALL enter VALIDA; VALIDA lasts exactly one cycle.
REQ-020 In the cycle after VALIDA is entered, exactly one strobe SHALL be high for one cycle, selected by key class; tecla (and operacion for A-D) updated in the same cycle and held until the next accepted key.
REQ-021 operacion SHALL change only on operator keys.
REQ-022 ESPERAR_SOLTAR: filas stays frozen; latched column high -> ANTIREBOTE_SOLTAR.
REQ-023 ANTIREBOTE_SOLTAR: ANTIREBOTE_CICLOS consecutive high cycles -> ESCANEAR at next row; any low cycle -> counter clear, back to ESPERAR_SOLTAR.
REQ-024 A held key SHALL produce exactly one strobe, no auto-repeat; no strobe SHALL occur outside the VALIDA exit cycle.
REQ-025 Strobes SHALL never be asserted simultaneously.

Reset
REQ-026 While reset is high: state ESCANEAR, filas = 4'b1110, tecla = 4'h0, operacion = 2'b00, all strobes 0, counters 0, synchronizer flops 4'b1111.
REQ-027 Reset asserted mid-press or mid-debounce SHALL abort with no strobe; the key must be released and re-pressed (or remain held through a full debounce after reset release) to be accepted.

Structure
REQ-028 Package calculadora_pkg SHALL hold FSM state encoding, key codes (4'h0-4'hF), operation codes, default parameter values.
REQ-029 A sub-module sincronizador (parameterised width, 2-flop) SHALL implement REQ-014.
REQ-030 All outputs SHALL be driven from registers.

Verification (SCAN_CICLOS=4, ANTIREBOTE_CICLOS=8)
REQ-031 Clean press '5' (row1,col1) held 50 cycles -> one numero_en pulse, tecla=4'h5, no other strobes.
REQ-032 '#' bouncing every 3 cycles for 20 cycles then stable 30 cycles -> single igual_en pulse after 8 stable cycles, tecla=4'hF.
REQ-033 'B' held 200 cycles -> one operando_en, operacion=2'b01, filas=4'b1101 throughout hold, no repeat.
REQ-034 Columns 0 and 1 both low while row2 driven -> no strobe, scanning continues to row3.
REQ-035 Reset pulse at debounce count 5 of '0' -> outputs at reset values immediately, no strobe; subsequent clean '0' press -> numero_en, tecla=4'h0.
REQ-036 '7' accepted, 3-cycle low glitch during release debounce -> no second strobe; next '8' press -> numero_en, tecla=4'h8.
